// File: rtl/bcd_pkg.sv
// Shared types and constants for the binary-to-BCD converter.
// Holds the double-dabble adjust constants and the digit-count helper
// used to check that the output has enough digits for the input width.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    // A digit at or above this value would overflow past 9 after the next
    // shift, so it gets pre-corrected before shifting.
    localparam bcd_digit_t BCD_ADJ_THRESH = 4'd5;
    localparam bcd_digit_t BCD_ADJ_ADD    = 4'd3;

    // Smallest number of decimal digits that can hold 2**in_w - 1.
    function automatic int min_digits(input int in_w);
        longint max_val;
        longint pow10;
        int     d;
        max_val = (longint'(1) << in_w) - 1;
        pow10   = 10;
        d       = 1;
        for (int i = 0; i < 20; i++) begin
            if (pow10 <= max_val) begin
                pow10 = pow10 * 10;
                d     = d + 1;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/bcd_dabble.sv
// Combinational binary-to-packed-BCD conversion (shift-add-3).
// Latency: zero cycles, pure function of bin.
// No handshake; output follows the input continuously.
module bcd_dabble
    import bcd_pkg::*;
#(
    parameter int IN_W   = 4,
    parameter int DIGITS = 2
) (
    input  logic [IN_W-1:0]     bin,
    output logic [4*DIGITS-1:0] bcd
);

    logic [4*DIGITS-1:0] acc;

    // Shift input bits in MSB-first, correcting any digit >= 5 before each shift.
    always_comb begin
        acc = '0;
        for (int i = IN_W - 1; i >= 0; i--) begin
            for (int k = 0; k < DIGITS; k++) begin
                if (acc[4*k +: 4] >= BCD_ADJ_THRESH) begin
                    acc[4*k +: 4] = acc[4*k +: 4] + BCD_ADJ_ADD;
                end
            end
            acc = {acc[4*DIGITS-2:0], bin[i]};
        end
    end

    assign bcd = acc;

endmodule

// File: rtl/bcd.sv
// Registered binary-to-BCD converter; digit k at [4k+3:4k], k=0 is units.
// Latency: one clock, one conversion per cycle.
// No backpressure; the output tracks the input every cycle.
module bcd
    import bcd_pkg::*;
#(
    parameter int IN_W   = 4,
    parameter int DIGITS = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IN_W-1:0]     Data_in,
    output logic [4*DIGITS-1:0] Data_out
);

    // Too few digits would silently drop the high decimal digit.
    if (DIGITS < min_digits(IN_W)) begin : g_digits_check
        $error("bcd: DIGITS too small for IN_W");
    end

    logic [4*DIGITS-1:0] conv;

    bcd_dabble #(
        .IN_W   (IN_W),
        .DIGITS (DIGITS)
    ) u_dabble (
        .bin (Data_in),
        .bcd (conv)
    );

    // Output register so downstream sees a glitch-free value; reset wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            Data_out <= '0;
        end else begin
            Data_out <= conv;
        end
    end

endmodule

// File: tb/tb_bcd.sv
module tb_bcd;

    logic       clk;
    logic       rst;
    logic [3:0] Data_in;
    logic [7:0] Data_out;

    int checks   = 0;
    int failures = 0;

    bcd #(.IN_W(4), .DIGITS(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .Data_in  (Data_in),
        .Data_out (Data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: decimal split by div/mod, independent of the shift-add method.
    function automatic logic [7:0] ref_bcd(input logic [3:0] v);
        int n;
        logic [3:0] t;
        logic [3:0] u;
        n = int'(v);
        t = 4'(n / 10);
        u = 4'(n % 10);
        return {t, u};
    endfunction

    // Drive one cycle, then check the hand value, the model and digit range.
    task automatic cyc(input string tag, input logic [3:0] din, input logic r,
                       input logic [7:0] exp);
        logic [7:0] mdl;
        Data_in = din;
        rst     = r;
        mdl     = r ? 8'h00 : ref_bcd(din);
        @(posedge clk);
        #1;
        chk(tag, Data_out, exp);
        chk({tag, "_model"}, Data_out, mdl);
        chk({tag, "_digits"}, {6'd0, (Data_out[7:4] <= 4'd9), (Data_out[3:0] <= 4'd9)}, 8'h03);
    endtask

    initial begin
        rst     = 1'b1;
        Data_in = 4'd7;
        @(posedge clk);
        #1;

        // Reset held with a nonzero input, then release.
        cyc("rst0", 4'd7, 1'b1, 8'h00);
        cyc("rst1", 4'd7, 1'b1, 8'h00);
        cyc("rel",  4'd7, 1'b0, 8'h07);

        // Single-digit sweep.
        for (int i = 0; i < 10; i++) begin
            cyc($sformatf("lo%0d", i), 4'(i), 1'b0, {4'h0, 4'(i)});
        end

        // Two-digit sweep.
        for (int i = 10; i < 16; i++) begin
            cyc($sformatf("hi%0d", i), 4'(i), 1'b0, {4'h1, 4'(i - 10)});
        end

        // Wrap 15 -> 0.
        cyc("wrap15", 4'd15, 1'b0, 8'h15);
        cyc("wrap0",  4'd0,  1'b0, 8'h00);

        // Hold at 9.
        for (int i = 0; i < 5; i++) begin
            cyc($sformatf("hold%0d", i), 4'd9, 1'b0, 8'h09);
        end

        // Mid-sweep reset pulse.
        cyc("ms10",  4'd10, 1'b0, 8'h10);
        cyc("ms11",  4'd11, 1'b0, 8'h11);
        cyc("msrst", 4'd12, 1'b1, 8'h00);
        cyc("ms12",  4'd12, 1'b0, 8'h12);
        cyc("ms13",  4'd13, 1'b0, 8'h13);

        // A few scattered values back to back.
        cyc("v4",  4'd4,  1'b0, 8'h04);
        cyc("v14", 4'd14, 1'b0, 8'h14);
        cyc("v5",  4'd5,  1'b0, 8'h05);
        cyc("v10", 4'd10, 1'b0, 8'h10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
